schoolbook_digit_serial: RTL and testbench

Parametrised digit-serial schoolbook multiplier for large unsigned integers. It computes c = a × b by scanning b in D-bit digits, one digit per cycle, and accumulating shifted partial products. Valid/ready handshakes on the operand and result sides let it sit in streaming crypto datapaths, such as ECC field arithmetic or RSA blocks, with back-pressure. An optional multiply-accumulate mode adds a third operand.

---
 rtl/schoolbook_pkg.sv | 22 ++
 rtl/schoolbook_pp.sv | 13 +
 rtl/schoolbook_digit_serial.sv | 93 +++++++++
 tb/tb_schoolbook_digit_serial.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/schoolbook_pkg.sv
// Shared types and elaboration helpers for the digit-serial schoolbook multiplier.
package schoolbook_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int ndig(input int wb, input int d);
        return (wb + d - 1) / d;
    endfunction

endpackage

// File: rtl/schoolbook_pp.sv
// Combinational a x D-bit digit partial product, kept separate so the digit multiplier can be tuned on its own.
module schoolbook_pp #(
    parameter int WA = 571,
    parameter int D  = 8
) (
    input  logic [WA-1:0]   a,
    input  logic [D-1:0]    digit,
    output logic [WA+D-1:0] p
);

    assign p = (WA+D)'(a) * (WA+D)'(digit);

endmodule

// File: rtl/schoolbook_digit_serial.sv
// Digit-serial schoolbook multiplier c = a * b (plus acc_in when SCHOOLBOOK_MAC_EN is defined),
// scanning b one D-bit digit per cycle with valid/ready handshakes on both sides.
module schoolbook_digit_serial
    import schoolbook_pkg::*;
#(
    parameter int WA = 571,
    parameter int WB = 571,
    parameter int D  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
`ifdef SCHOOLBOOK_MAC_EN
    input  logic [WA+WB-1:0] acc_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WA+WB-1:0] c
);

    localparam int NDIG = ndig(WB, D);
    localparam int CW   = WA + WB;
    localparam int BW   = NDIG * D;
    localparam int KW   = clog2(NDIG + 1);
    localparam int PW   = WA + D;

    state_t          state, state_nx;
    logic [KW-1:0]   k;
    logic [WA-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [CW-1:0]   acc;
    logic [PW-1:0]   pp;
    logic [CW-1:0]   pp_sh;
    logic [31:0]     sh;
    logic            accept;
    logic            last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (k == KW'(NDIG - 1));
    assign c         = acc;

    // b_q shifts right each RUN cycle, so the current digit is always its low D bits.
    schoolbook_pp #(.WA(WA), .D(D)) u_pp (
        .a     (a_q),
        .digit (b_q[D-1:0]),
        .p     (pp)
    );

    assign sh    = 32'(k) * 32'(D);
    assign pp_sh = CW'(pp) << sh;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q <= a;
                b_q <= BW'(b);
`ifdef SCHOOLBOOK_MAC_EN
                acc <= acc_in;
`else
                acc <= '0;
`endif
                k   <= '0;
            end else if (state == RUN) begin
                acc <= acc + pp_sh;
                b_q <= b_q >> D;
                k   <= k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_schoolbook_digit_serial.sv
// Directed bench for schoolbook_digit_serial: small (8x8,D=3), default, D=1 and D=WB configurations.
module tb_schoolbook_digit_serial;

    logic          clk;
    logic          rst;
    logic [3:0]    in_vld;
    logic [3:0]    in_rdy;
    logic [3:0]    out_vld;
    logic [3:0]    out_rdy;
    logic [570:0]  a_v;
    logic [570:0]  b_v;
`ifdef SCHOOLBOOK_MAC_EN
    logic [1141:0] acc_v;
`endif
    logic [15:0]   c_s;
    logic [1141:0] c_g;
    logic [127:0]  c_1;
    logic [127:0]  c_w;

    int n_chk;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    schoolbook_digit_serial #(.WA(8), .WB(8), .D(3)) u_s (
        .clk(clk), .rst(rst), .in_valid(in_vld[0]), .in_ready(in_rdy[0]),
        .a(a_v[7:0]), .b(b_v[7:0]),
`ifdef SCHOOLBOOK_MAC_EN
        .acc_in(acc_v[15:0]),
`endif
        .out_valid(out_vld[0]), .out_ready(out_rdy[0]), .c(c_s)
    );

    schoolbook_digit_serial u_g (
        .clk(clk), .rst(rst), .in_valid(in_vld[1]), .in_ready(in_rdy[1]),
        .a(a_v), .b(b_v),
`ifdef SCHOOLBOOK_MAC_EN
        .acc_in(acc_v),
`endif
        .out_valid(out_vld[1]), .out_ready(out_rdy[1]), .c(c_g)
    );

    schoolbook_digit_serial #(.WA(64), .WB(64), .D(1)) u_1 (
        .clk(clk), .rst(rst), .in_valid(in_vld[2]), .in_ready(in_rdy[2]),
        .a(a_v[63:0]), .b(b_v[63:0]),
`ifdef SCHOOLBOOK_MAC_EN
        .acc_in(acc_v[127:0]),
`endif
        .out_valid(out_vld[2]), .out_ready(out_rdy[2]), .c(c_1)
    );

    schoolbook_digit_serial #(.WA(64), .WB(64), .D(64)) u_w (
        .clk(clk), .rst(rst), .in_valid(in_vld[3]), .in_ready(in_rdy[3]),
        .a(a_v[63:0]), .b(b_v[63:0]),
`ifdef SCHOOLBOOK_MAC_EN
        .acc_in(acc_v[127:0]),
`endif
        .out_valid(out_vld[3]), .out_ready(out_rdy[3]), .c(c_w)
    );

    function automatic logic [1141:0] get_c(input int sel);
        case (sel)
            0:       return 1142'(c_s);
            1:       return c_g;
            2:       return 1142'(c_1);
            default: return 1142'(c_w);
        endcase
    endfunction

    task automatic check(input string tag, input logic [1141:0] got, input logic [1141:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at posedge+#1.
    task automatic start(input int sel, input logic [570:0] av, input logic [570:0] bv);
        a_v = av;
        b_v = bv;
        in_vld[sel] = 1'b1;
        check("in_ready_idle", 1142'(in_rdy[sel]), 1142'(1));
        @(posedge clk); #1;
        in_vld[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, input logic [1141:0] exp, input int lat);
        int cyc;
        cyc = 0;
        while (!out_vld[sel] && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 1142'(cyc), 1142'(lat));
        check("product", get_c(sel), exp);
    endtask

    task automatic take(input int sel);
        out_rdy[sel] = 1'b1;
        @(posedge clk); #1;
        out_rdy[sel] = 1'b0;
        check("out_valid_drop", 1142'(out_vld[sel]), 1142'(0));
        check("in_ready_back", 1142'(in_rdy[sel]), 1142'(1));
    endtask

    task automatic run_op(input int sel, input logic [570:0] av, input logic [570:0] bv,
                          input logic [1141:0] exp, input int lat);
        start(sel, av, bv);
        wait_done(sel, exp, lat);
        take(sel);
    endtask

    logic [63:0]  ta [4];
    logic [63:0]  tb [4];
    logic [127:0] te [4];

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst     = 1'b0;
        in_vld  = '0;
        out_rdy = '0;
        a_v     = '0;
        b_v     = '0;
`ifdef SCHOOLBOOK_MAC_EN
        acc_v   = '0;
`endif
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        te[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        ta[1] = 64'h1234_5678_9ABC_DEF0; tb[1] = 64'h10;
        te[1] = 128'h0000_0000_0000_0001_2345_6789_ABCD_EF00;
        ta[2] = 64'hDEAD_BEEF;           tb[2] = 64'h1_0000_0001;
        te[2] = 128'hDEAD_BEEF_DEAD_BEEF;
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h8000_0000_0000_0000;
        te[3] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 1142'(in_rdy), 1142'(4'hF));
        check("rst_out_valid", 1142'(out_vld), 1142'(0));
        check("rst_c_small", 1142'(c_s), 1142'(0));
        check("rst_c_default", c_g, 1142'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Small config: NDIG = 3, including a padded top digit.
        run_op(0, 571'd6, 571'd5, 1142'd30, 3);
        run_op(0, 571'd3, 571'd200, 1142'd600, 3);

        // Back-pressure, with in_valid held across the result handshake.
        start(0, 571'd255, 571'd255);
        wait_done(0, 1142'd65025, 3);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_c", 1142'(c_s), 1142'd65025);
            check("bp_out_valid", 1142'(out_vld[0]), 1142'(1));
            check("bp_in_ready", 1142'(in_rdy[0]), 1142'(0));
        end
        a_v = 571'd5;
        b_v = 571'd7;
        in_vld[0]  = 1'b1;
        out_rdy[0] = 1'b1;
        @(posedge clk); #1;
        out_rdy[0] = 1'b0;
        check("rel_out_valid", 1142'(out_vld[0]), 1142'(0));
        check("rel_in_ready", 1142'(in_rdy[0]), 1142'(1));
        @(posedge clk); #1;
        in_vld[0] = 1'b0;
        check("next_accepted", 1142'(in_rdy[0]), 1142'(0));
        wait_done(0, 1142'd35, 3);
        take(0);

        // Default config: NDIG = 72.
        run_op(1, {571{1'b1}}, {571{1'b1}}, {{570{1'b1}}, 1'b0, {570{1'b0}}, 1'b1}, 72);
        run_op(1, {571{1'b1}}, 571'd0, 1142'd0, 72);

        // Reset during RUN aborts with no partial result.
        start(1, 571'd12345, 571'd6789);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_in_ready", 1142'(in_rdy[1]), 1142'(1));
        check("abort_out_valid", 1142'(out_vld[1]), 1142'(0));
        check("abort_c", c_g, 1142'(0));
        run_op(1, 571'd3, 571'd5, 1142'd15, 72);

        // D=1 and D=WB corners share one vector table.
        for (int i = 0; i < 4; i++) begin
            run_op(2, 571'(ta[i]), 571'(tb[i]), 1142'(te[i]), 64);
            run_op(3, 571'(ta[i]), 571'(tb[i]), 1142'(te[i]), 1);
        end

`ifdef SCHOOLBOOK_MAC_EN
        acc_v = 1142'd1000;
        run_op(0, 571'd15, 571'd17, 1142'd1255, 3);
        acc_v = 1142'hFFFF;
        run_op(0, 571'd1, 571'd1, 1142'd0, 3);
        acc_v = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
